// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: button conditioning, point/win detection and
// the game-state bus that gates the ball block.

// Two-flop synchronizer plus counter debouncer; emits a one-cycle pulse
// when the accepted level goes from released to pressed.
module pong_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  logic       sync1;
  logic       sync2;
  logic       stable;
  logic [7:0] cnt;

  // Synchronize, count how long the new level persists, accept it at the limit.
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= 8'd0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= 8'd0;
        // stable was the opposite level, so sync2=1 means a 0->1 change
        press  <= sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// Game-flow FSM.
//   state   | meaning
//   S_IDLE  | waiting for first start press, ball parked
//   S_SERVE | ball frozen for SERVE_MS cycles after a point or restart
//   S_PLAY  | ball moving, watching scores and pause
//   S_PAUSE | ball frozen by player until next pause press
//   S_OVER  | match decided, winner shown until start press
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_MS    = 1000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] p1_scr,
  input  logic [3:0] p2_scr,
  output logic [1:0] stateGm,
  output logic [1:0] winner,
  output logic       game_rst_n,
  output logic       paused
);
  localparam logic [3:0]  WIN_4    = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LD = 16'(SERVE_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_PAUSE,
    S_OVER
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] serve_cnt, serve_cnt_nxt;
  logic [3:0]  prev1, prev2;
  logic [1:0]  winner_nxt;
  logic [1:0]  gm_nxt;
  logic        rst_n_nxt;
  logic        start_press;
  logic        pause_press;
  logic        point;

  pong_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn     (btn_start),
    .press   (start_press)
  );

  pong_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_pause (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn     (btn_pause),
    .press   (pause_press)
  );

  assign point = (p1_scr != prev1) || (p2_scr != prev2);

  // Next-state, serve timer, winner latch and registered output encoding.
  always_comb begin
    state_nxt     = state;
    serve_cnt_nxt = serve_cnt;
    winner_nxt    = winner;
    rst_n_nxt     = 1'b1;
    gm_nxt        = 2'b00;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          state_nxt     = S_SERVE;
          serve_cnt_nxt = SERVE_LD;
        end
      end
      S_SERVE: begin
        if (serve_cnt <= 16'd1) begin
          state_nxt     = S_PLAY;
          serve_cnt_nxt = 16'd0;
        end else begin
          serve_cnt_nxt = serve_cnt - 16'd1;
        end
      end
      S_PLAY: begin
        // a scored point outranks a pause arriving in the same cycle
        if (point) begin
          if (p1_scr >= WIN_4) begin
            state_nxt  = S_OVER;
            winner_nxt = 2'b01;
          end else if (p2_scr >= WIN_4) begin
            state_nxt  = S_OVER;
            winner_nxt = 2'b10;
          end else begin
            state_nxt     = S_SERVE;
            serve_cnt_nxt = SERVE_LD;
          end
        end else if (pause_press) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_press) state_nxt = S_PLAY;
      end
      S_OVER: begin
        if (start_press) begin
          state_nxt     = S_SERVE;
          serve_cnt_nxt = SERVE_LD;
          winner_nxt    = 2'b00;
          rst_n_nxt     = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_SERVE, S_PAUSE: gm_nxt = 2'b10;
      S_PLAY:           gm_nxt = 2'b01;
      S_OVER:           gm_nxt = 2'b11;
      default:          gm_nxt = 2'b00;
    endcase
  end

  // State, timer, score history and outputs all update together.
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      state      <= S_IDLE;
      serve_cnt  <= 16'd0;
      prev1      <= 4'd0;
      prev2      <= 4'd0;
      stateGm    <= 2'b00;
      winner     <= 2'b00;
      game_rst_n <= 1'b1;
      paused     <= 1'b0;
    end else begin
      state      <= state_nxt;
      serve_cnt  <= serve_cnt_nxt;
      prev1      <= p1_scr;
      prev2      <= p2_scr;
      stateGm    <= gm_nxt;
      winner     <= winner_nxt;
      game_rst_n <= rst_n_nxt;
      paused     <= (state_nxt == S_PAUSE);
    end
  end
endmodule
